// File: rtl/kbd_char_fifo.sv
// kbd_char_fifo
//   Character FIFO between the PS/2 keyboard driver and console logic.
//   Each rising edge of the driver's valid bit (key_in[15]) writes one
//   ASCII byte. Bytes are popped through a registered read port. A count
//   of buffered carriage returns drives line_ready.
module kbd_char_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   key_in,
   input  logic          rd_en,
   input  logic          clr_ovf,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          line_ready,
   output logic          overflow
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [7:0]    CR_CODE  = 8'h0D;

   // Storage; contents are not reset. Only wptr/rptr/count give it meaning.
   logic [7:0]    mem_q [DEPTH];

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   line_cnt_q, line_cnt_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          ovf_q, ovf_d;
   logic          v_q, v_d;

   logic          empty_s;
   logic          full_s;
   logic          wr_req_s;
   logic          wr_acc_s;
   logic          wr_drop_s;
   logic          rd_fire_s;
   logic          wr_is_cr_s;
   logic          rd_is_cr_s;
   logic [7:0]    rd_word_s;

   // Bits [14:8] of the driver word carry nothing for this block.
   logic          key_hi_unused_s;
   assign key_hi_unused_s = ^key_in[14:8];

   // Status decode, write/read qualification and the popped word.
   always_comb begin
      empty_s    = (count_q == {(AW+1){1'b0}});
      full_s     = (count_q == FULL_CNT);
      wr_req_s   = key_in[15] & ~v_q & (key_in[7:0] != 8'h00);
      rd_fire_s  = rd_en & ~empty_s;
      wr_acc_s   = wr_req_s & (~full_s | rd_fire_s);
      wr_drop_s  = wr_req_s & full_s & ~rd_fire_s;
      rd_word_s  = mem_q[rptr_q];
      wr_is_cr_s = wr_acc_s & (key_in[7:0] == CR_CODE);
      rd_is_cr_s = rd_fire_s & (rd_word_s == CR_CODE);
   end

   // Next-state for pointers, occupancy, line count, read port and flags.
   always_comb begin
      v_d        = key_in[15];
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      line_cnt_d = line_cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ovf_d      = ovf_q;

      if (wr_acc_s) begin
         wptr_d = wptr_q + PTR_ONE;
      end else begin
         wptr_d = wptr_q;
      end

      if (rd_fire_s) begin
         rptr_d     = rptr_q + PTR_ONE;
         rd_data_d  = rd_word_s;
         rd_valid_d = 1'b1;
      end else begin
         rptr_d     = rptr_q;
         rd_data_d  = rd_data_q;
         rd_valid_d = 1'b0;
      end

      case ({wr_acc_s, rd_fire_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case ({wr_is_cr_s, rd_is_cr_s})
         2'b10:   line_cnt_d = line_cnt_q + CNT_ONE;
         2'b01:   line_cnt_d = line_cnt_q - CNT_ONE;
         default: line_cnt_d = line_cnt_q;
      endcase

      // A drop in the same cycle as a clear keeps the flag set.
      if (wr_drop_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Control state register; v_q resets high so a held valid is not captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= {AW{1'b0}};
         rptr_q     <= {AW{1'b0}};
         count_q    <= {(AW+1){1'b0}};
         line_cnt_q <= {(AW+1){1'b0}};
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         v_q        <= 1'b1;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         line_cnt_q <= line_cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         v_q        <= v_d;
      end
   end

   // Storage write; a full FIFO popped this cycle reads the old word first.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_q[wptr_q] <= key_in[7:0];
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign empty      = empty_s;
   assign full       = full_s;
   assign count      = count_q;
   assign line_ready = (line_cnt_q != {(AW+1){1'b0}});
   assign overflow   = ovf_q;

endmodule
